// File: rtl/rca_wide_seq.sv
// Multi-word add/subtract sequencer driving one shared 32-bit ripple-carry adder/subtractor.
// Operands are walked LSW first with the carry chained through carry_q between words.
//
//   state  | meaning
//   IDLE   | ready for a request; adder inputs driven to 0
//   RUN    | one word per cycle through the adder, idx = 0..WORDS-1
//   FIN    | result registers settle; adder idle, nothing visible yet
//   DONE   | result valid and held until the consumer accepts it
module rca_wide_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [32*WORDS-1:0] req_a_i,
    input  logic [32*WORDS-1:0] req_b_i,
    input  logic                req_sub_i,
    input  logic                req_cin_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [32*WORDS-1:0] res_sum_o,
    output logic                res_cout_o,
    output logic                res_ovf_o,
    output logic [31:0]         add_a_o,
    output logic [31:0]         add_b_o,
    output logic                add_c_o,
    output logic                add_sel_o,
    input  logic [31:0]         add_sum_i,
    input  logic                add_cout_i
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [WORDS-1:0][31:0] a_q, a_d;
    logic [WORDS-1:0][31:0] b_q, b_d;
    logic [WORDS-1:0][31:0] sum_q, sum_d;
    logic                   sub_q, sub_d;
    logic                   cin_q, cin_d;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d;
    logic                   ovf_q, ovf_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            sub_q   <= sub_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        sub_d     = sub_q;
        cin_d     = cin_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        add_a_o   = '0;
        add_b_o   = '0;
        add_c_o   = 1'b0;
        add_sel_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    sub_d   = req_sub_i;
                    cin_d   = req_cin_i;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a_o   = a_q[idx_q];
                add_b_o   = b_q[idx_q];
                add_sel_o = sub_q;
                // The adder applies Sel^C itself, so the chained carry is pre-flipped for subtract.
                add_c_o   = (idx_q == '0) ? cin_q : (carry_q ^ sub_q);
                sum_d[idx_q] = add_sum_i;
                carry_d      = add_cout_i;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout_i;
                    ovf_d   = (a_q[WORDS-1][31] ^ add_sum_i[31])
                            & ((b_q[WORDS-1][31] ^ sub_q) ^ add_sum_i[31]);
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_FIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign res_valid_o = (state_q == S_DONE);
    assign res_sum_o   = sum_q;
    assign res_cout_o  = cout_q;
    assign res_ovf_o   = ovf_q;

endmodule
